// File: rtl/ser8_tx.sv
// ser8_tx: parallel-to-serial launch stage with valid/ready intake and a frame qualifier.
// Optional trailing even-parity bit is enabled by defining PARITY_EN.
module ser8_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit NO_GAP = (GAP_CYCLES == 0);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic             sout_n, sframe_n, done_n;
  logic             xfer, last_serial;
`ifdef PARITY_EN
  logic             par, par_n;
`endif

  // The final serial cycle of a frame is where a back-to-back word may be taken.
  always_comb begin
`ifdef PARITY_EN
    last_serial = (state == PAR);
`else
    last_serial = (state == SHIFT) && (cnt == CNT_LAST);
`endif
    din_ready = !rst && ((state == IDLE) || (NO_GAP && last_serial));
  end

  assign xfer = din_valid && din_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    sout_n   = 1'b0;
    sframe_n = 1'b0;
    done_n   = 1'b0;
`ifdef PARITY_EN
    par_n    = par;
`endif

    case (state)
      SHIFT: begin
        if (cnt != CNT_LAST) begin
          cnt_n    = cnt + 1'b1;
          shreg_n  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          sout_n   = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
          sframe_n = 1'b1;
        end
`ifdef PARITY_EN
        else begin
          state_n  = PAR;
          sout_n   = par;
          sframe_n = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gcnt == GAP_LAST) state_n = IDLE;
        else                  gcnt_n  = gcnt + 4'd1;
      end
      default: ;
    endcase

    if (last_serial) begin
      done_n  = 1'b1;
      state_n = NO_GAP ? IDLE : GAP;
      gcnt_n  = 4'd0;
    end

    // A transfer loads the word and launches its first bit on the same edge.
    if (xfer) begin
      state_n  = SHIFT;
      cnt_n    = '0;
      shreg_n  = din;
      sout_n   = MSB_FIRST ? din[WIDTH-1] : din[0];
      sframe_n = 1'b1;
`ifdef PARITY_EN
      par_n    = ^din;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      gcnt   <= 4'd0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      done   <= 1'b0;
`ifdef PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      gcnt   <= gcnt_n;
      sout   <= sout_n;
      sframe <= sframe_n;
      done   <= done_n;
`ifdef PARITY_EN
      par    <= par_n;
`endif
    end
  end

endmodule

// File: doc/ser8_tx.md
Name: ser8_tx

Overview:
Byte-to-serial launch stage. Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock with a frame qualifier. It is the transmit-side counterpart of the reg8 parallel capture register: it drives the serial/launch end of the same byte datapath and feeds a deserializing capture stage. The timing-path tooling uses it as a deterministic multi-cycle launch source.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 first
GAP_CYCLES, 0, idle cycles forced between frames (0..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept din this cycle
sout  output  1  serial data bit (registered)
sframe  output  1  high on every cycle sout carries a frame bit (registered)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse in the cycle after a frame's last bit

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: sout=0, sframe=0, busy=0, done=0, state=IDLE, shift register=0, bit counter=0. din_ready is forced to 0 while rst=1.
- States: IDLE, SHIFT, PAR (present only with PARITY_EN), GAP.
- Transfer occurs on a clk edge where din_valid && din_ready. din is copied into the shift register at that edge. din may change afterwards without effect.
- Latency: first bit on sout and sframe=1 in the cycle after the transfer edge.
- SHIFT: one bit per cycle for exactly WIDTH cycles, in the order set by MSB_FIRST. The bit counter runs 0..WIDTH-1.
- After the last data bit: go to PAR if enabled. Otherwise go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: sframe=0, sout=0, din_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
- din_ready = 1 in IDLE. When GAP_CYCLES=0 it is also 1 in the final serial cycle of a frame: the last data bit, or the PAR cycle if enabled. This allows back-to-back frames.
- Back-to-back: a transfer in the final serial cycle starts the next frame's first bit the following cycle. sframe stays continuously high. done still pulses in that cycle.
- done pulses once per completed frame, in the cycle after the final serial bit, regardless of GAP.
- Outside frames: sout=0 and sframe=0. din_valid while din_ready=0 is ignored. No data loss: the source must hold din_valid.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). The partial frame is dropped, done does not pulse, and the first post-reset cycle is IDLE.
- busy=1 from the cycle after the transfer until GAP/PAR/SHIFT exits to IDLE.

Optional Feature:
PARITY_EN.
- Defined: after the WIDTH data bits, one extra PAR cycle with sframe=1 and sout = even parity of the word (XOR of all bits). done moves one cycle later.
- Undefined: no PAR state. Frames are exactly WIDTH bits.

Test Plan:
- MSB_FIRST=1, din=8'hA5 accepted at edge T -> sout=1,0,1,0,0,1,0,1 at cycles T+1..T+8; sframe high exactly those 8 cycles; done=1 at T+9; din_ready=1 at T+9.
- MSB_FIRST=0, din=8'h01 -> sout=1 then seven 0s; sframe 8 cycles; busy low again at T+9.
- GAP_CYCLES=0, din_valid held with 8'hA5 then 8'h3C -> sframe high for 16 consecutive cycles; second frame sout=0,0,1,1,1,1,0,0; done pulses at T+9 and T+17.
- GAP_CYCLES=2, two words queued -> din_ready low at T+9,T+10 and high at T+11; second frame first bit at T+12.
- Assert rst at T+4 of a frame for 1 cycle -> sout/sframe/busy go 0 immediately, no done pulse, din_ready=1 the cycle after rst falls, and a new 8'hFF transfers cleanly.
- PARITY_EN defined: din=8'hA5 -> 9th bit 0, done at T+10; din=8'h07 -> 9th bit 1.
